fetch_unit: RTL and testbench

//   SISC instruction fetch stage: holds PC and IR, runs the instruction-memory read

---
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of the SISC core. Holds the program counter and the
//   instruction register, performs the instruction-memory read handshake when
//   the control FSM asks for a fetch, and presents opcode/mm back to control.
//
//   Ports
//     clk         system clock, all state updates on the rising edge
//     rst_f       asynchronous active-high reset
//     fetch_req   pulse: start one fetch (ignored while busy)
//     pc_write    load PC with a branch target (deferred as pending while busy)
//     pc_sel      0 = absolute target br_addr, 1 = PC + signed br_addr
//     br_addr     branch target or signed offset
//     imem_req    read request to instruction memory (REQ and WAIT states)
//     imem_addr   read address, always the current PC
//     imem_ack    memory data valid this cycle (honoured only in WAIT)
//     imem_rdata  instruction word from memory
//     ir          instruction register
//     opcode      ir[31:28]
//     mm          ir[27:24]
//     ir_valid    one-cycle pulse when ir has been refreshed
//     busy        high in any state other than IDLE
//     fetch_err   sticky flag: a fetch timed out (cleared by reset only)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              fetch_req,
    input  logic              pc_write,
    input  logic              pc_sel,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    output logic [3:0]        opcode,
    output logic [3:0]        mm,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t             state_reg;
    state_t             state_next;
    logic [ADDR_W-1:0]  pc_reg;
    logic [ADDR_W-1:0]  pend_target_reg;
    logic               pend_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [31:0]        ir_reg;
    logic               err_reg;

    logic [ADDR_W-1:0]  br_target;
    logic               ack_hit;
    logic               timeout_hit;

    // br_addr is already ADDR_W wide, so sign-extending it to ADDR_W is the
    // identity and the relative target is a plain modular add.
    assign br_target   = pc_sel ? (pc_reg + br_addr) : br_addr;

    assign ack_hit     = (state_reg == WAIT) && imem_ack;
    // cnt_reg holds the number of WAIT cycles already spent, so the abort
    // fires in the TIMEOUT-th WAIT cycle. A same-cycle ack wins.
    assign timeout_hit = (state_reg == WAIT) && !imem_ack &&
                         (cnt_reg == CNT_W'(TIMEOUT - 1));

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM next state and outputs ----------------
    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        ir_valid   = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (fetch_req) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                imem_req   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                imem_req = 1'b1;
                if (ack_hit || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ir_valid   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            pc_reg          <= '0;
            pend_target_reg <= '0;
            pend_reg        <= 1'b0;
            cnt_reg         <= '0;
            ir_reg          <= '0;
            err_reg         <= 1'b0;
        end else begin
            if ((state_reg == IDLE) || (state_reg == DONE)) begin
                // No outstanding memory access: a branch lands on PC directly.
                // In IDLE this also lets a same-cycle fetch use the new PC.
                if (pc_write) begin
                    pc_reg <= br_target;
                end
            end else if (ack_hit || timeout_hit) begin
                // Fetch completes: a write in this very cycle is the newest
                // branch and outranks an older pending one; otherwise fall
                // back to pending target, then PC+1 (only on a real ack).
                pend_reg <= 1'b0;
                if (pc_write) begin
                    pc_reg <= br_target;
                end else if (pend_reg) begin
                    pc_reg <= pend_target_reg;
                end else if (ack_hit) begin
                    pc_reg <= pc_reg + ADDR_W'(1);
                end
            end else if (pc_write) begin
                // PC must stay put while imem_addr is being presented, so the
                // target is parked until the fetch finishes.
                pend_reg        <= 1'b1;
                pend_target_reg <= br_target;
            end

            if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
                cnt_reg <= '0;
            end

            if (ack_hit) begin
                ir_reg <= imem_rdata;
            end else if (timeout_hit) begin
                ir_reg  <= '0;
                err_reg <= 1'b1;
            end
        end
    end

    assign imem_addr = pc_reg;
    assign ir        = ir_reg;
    assign opcode    = ir_reg[31:28];
    assign mm        = ir_reg[27:24];
    assign fetch_err = err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Scoreboard bench for fetch_unit. The stimulus process plays both the
//   control FSM and the instruction memory; for every fetch it issues it
//   queues the fetch address and, once the outcome is decided, the expected
//   result (ir, error flag, next PC, request length) taken from a simple
//   architectural PC/error model. A separate monitor checks each ir_valid
//   pulse and the request address against those queues.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_f;
    logic              fetch_req;
    logic              pc_write;
    logic              pc_sel;
    logic [ADDR_W-1:0] br_addr;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic [31:0]       ir;
    logic [3:0]        opcode;
    logic [3:0]        mm;
    logic              ir_valid;
    logic              busy;
    logic              fetch_err;

    fetch_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .fetch_req  (fetch_req),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .br_addr    (br_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .opcode     (opcode),
        .mm         (mm),
        .ir_valid   (ir_valid),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       ir;
        logic              err;
        logic [ADDR_W-1:0] pc_next;
        int                req_cycles;
    } exp_t;

    exp_t              sb[$];
    logic [ADDR_W-1:0] addr_q[$];

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;

    // architectural model state
    logic [ADDR_W-1:0] m_pc = '0;
    logic              m_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Branch target: absolute, or PC plus signed offset modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] tgt(input logic [ADDR_W-1:0] pc,
                                              input logic sel,
                                              input logic [ADDR_W-1:0] b);
        int s;
        if (!sel) return b;
        s = int'(pc) + int'($signed(b));
        return ADDR_W'(s & ((1 << ADDR_W) - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    int req_cnt  = 0;
    bit addr_bad = 0;
    always @(negedge clk) begin
        exp_t        e;
        logic [ADDR_W-1:0] a;
        if (rst_f) begin
            req_cnt  = 0;
            addr_bad = 0;
        end else begin
            if (imem_req) begin
                req_cnt++;
                if (addr_q.size() == 0 || imem_addr !== addr_q[0]) addr_bad = 1;
            end
            if (ir_valid) begin
                valid_seen++;
                if (sb.size() == 0 || addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ir_valid: pulse with no fetch outstanding");
                end else begin
                    e = sb.pop_front();
                    a = addr_q.pop_front();
                    chk($sformatf("ir@%0h", a), ir, e.ir);
                    chk("opcode", opcode, e.ir[31:28]);
                    chk("mm", mm, e.ir[27:24]);
                    chk("fetch_err", fetch_err, e.err);
                    chk("pc_after", imem_addr, e.pc_next);
                    chk("req_cycles", req_cnt, e.req_cycles);
                    chk("addr_stable", addr_bad, 0);
                    chk("req_low_in_done", imem_req, 0);
                end
                req_cnt  = 0;
                addr_bad = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_write(input logic sel, input logic [ADDR_W-1:0] b);
        pc_write = 1'b1;
        pc_sel   = sel;
        br_addr  = b;
        m_pc     = tgt(m_pc, sel, b);
        tick();
        pc_write = 1'b0;
    endtask

    // delay: WAIT cycle (1-based) in which ack arrives; > TIMEOUT means never.
    // n_mid: 0..2 random pc_writes while busy; -1 = absolute 0x0040 in WAIT 1.
    task automatic do_fetch(input int delay, input logic [31:0] data,
                            input bit pre, input logic psel, input logic [ADDR_W-1:0] pbr,
                            input int n_mid);
        exp_t              e;
        int                wait_len;
        int                wcyc[2];
        bit                pend;
        logic [ADDR_W-1:0] pt;
        logic [ADDR_W-1:0] fa;
        if (pre) begin
            pc_write = 1'b1;
            pc_sel   = psel;
            br_addr  = pbr;
            m_pc     = tgt(m_pc, psel, pbr);
        end
        fetch_req = 1'b1;
        fa        = m_pc;
        addr_q.push_back(fa);
        wait_len  = (delay <= TIMEOUT) ? delay : TIMEOUT;
        for (int i = 0; i < 2; i++) wcyc[i] = $urandom_range(0, wait_len);
        pend = 1'b0;
        pt   = '0;
        tick();
        pc_write  = 1'b0;
        fetch_req = 1'b0;
        // cycle 0 is REQ, cycles 1..wait_len are WAIT
        for (int c = 0; c <= wait_len; c++) begin
            if (n_mid < 0) begin
                if (c == 1) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b0;
                    br_addr  = 16'h0040;
                    pend     = 1'b1;
                    pt       = 16'h0040;
                end
            end else begin
                for (int i = 0; i < n_mid; i++) begin
                    if (wcyc[i] == c) begin
                        pc_write = 1'b1;
                        pc_sel   = 1'($urandom_range(0, 1));
                        br_addr  = ADDR_W'($urandom);
                        pend     = 1'b1;
                        pt       = tgt(fa, pc_sel, br_addr);
                    end
                end
            end
            if ($urandom_range(0, 3) == 0) fetch_req = 1'b1;
            if (c == delay) begin
                imem_ack   = 1'b1;
                imem_rdata = data;
            end else begin
                imem_ack   = (c == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                imem_rdata = $urandom;
            end
            tick();
            pc_write  = 1'b0;
            fetch_req = 1'b0;
            imem_ack  = 1'b0;
        end
        // now in DONE: decide outcome, spurious fetch_req/ack must be ignored
        if (delay <= TIMEOUT) begin
            e.ir      = data;
            e.pc_next = pend ? pt : fa + ADDR_W'(1);
        end else begin
            e.ir      = '0;
            m_err     = 1'b1;
            e.pc_next = pend ? pt : fa;
        end
        e.err        = m_err;
        e.req_cycles = 1 + wait_len;
        m_pc         = e.pc_next;
        sb.push_back(e);
        fetch_req  = 1'($urandom_range(0, 1));
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        tick();
        fetch_req = 1'b0;
        imem_ack  = 1'b0;
    endtask

    task automatic random_fetch();
        int d;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      d = TIMEOUT;
        else if (r == 1) d = TIMEOUT + 1 + $urandom_range(0, 4);
        else             d = $urandom_range(1, 8);
        do_fetch(d, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ADDR_W'($urandom), $urandom_range(0, 2));
        repeat ($urandom_range(0, 2)) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            tick();
            imem_ack = 1'b0;
        end
        if ($urandom_range(0, 4) == 0) idle_write(1'($urandom_range(0, 1)), ADDR_W'($urandom));
    endtask

    initial begin
        int saved_valid;
        rst_f      = 1'b1;
        fetch_req  = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        br_addr    = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ir", ir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_pc", imem_addr, 0);
        tick();
        rst_f = 1'b0;
        tick();

        // minimum-latency fetch of a known word from PC 0
        do_fetch(1, 32'h8823_0001, 0, 0, '0, 0);
        // ack five WAIT cycles late
        do_fetch(5, $urandom, 0, 0, '0, 0);
        // PC wraps from 0xFFFF
        idle_write(1'b0, 16'hFFFF);
        do_fetch(1, $urandom, 0, 0, '0, 0);
        // relative branch at PC=3 with offset -2
        idle_write(1'b0, 16'h0003);
        idle_write(1'b1, 16'hFFFE);
        do_fetch(2, $urandom, 0, 0, '0, 0);
        // branch issued during WAIT replaces PC+1
        do_fetch(3, $urandom, 0, 0, '0, -1);
        // same-cycle branch and fetch request
        do_fetch(1, $urandom, 1, 1'b1, 16'h0100, 0);
        // timeout, then fetch_err must stay set
        do_fetch(TIMEOUT + 3, $urandom, 0, 0, '0, 0);
        do_fetch(2, $urandom, 0, 0, '0, 0);

        repeat (60) random_fetch();

        // reset in the middle of WAIT, late ack after release
        saved_valid = valid_seen;
        fetch_req = 1'b1;
        addr_q.push_back(m_pc);
        tick();
        fetch_req = 1'b0;
        tick();
        tick();
        rst_f = 1'b1;
        void'(addr_q.pop_back());
        m_pc  = '0;
        m_err = 1'b0;
        tick();
        rst_f      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ir", ir, 0);
        chk("rstmid_err", fetch_err, 0);
        chk("rstmid_pc", imem_addr, 0);
        chk("rstmid_no_valid", valid_seen, saved_valid);
        tick();

        repeat (15) random_fetch();

        tick();
        tick();
        chk("sb_empty", sb.size(), 0);
        chk("addr_q_empty", addr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
